mem: RTL and testbench



---
 rtl/core_pkg.sv | 8 +
 rtl/mem.sv | 44 ++++
 tb/tb_mem.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Constants shared by the RV32 core and its unified instruction/data memory.
package core_pkg;

  localparam int XLEN      = 32;
  localparam int MEM_DEPTH = 64;
  localparam int MEM_AW    = 6;

endpackage

// File: rtl/mem.sv
// Unified instruction/data memory: single port, word addressed, read-first.
// Latency: read data registered, valid one cycle after addr is presented.
// Backpressure: none; the core FSM sequences addr/we and never stalls the memory.
module mem
  import core_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH,
  parameter int AW    = MEM_AW
) (
  input  logic [XLEN-1:0] addr,
  input  logic            clk,
  input  logic            we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  input  logic            rst
);

  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rdata_q = '0;
  logic [AW-1:0]   idx;
  logic            unused_addr_hi;

  // Upper address bits are ignored so accesses wrap modulo DEPTH.
  assign idx            = addr[AW-1:0];
  assign unused_addr_hi = ^addr[XLEN-1:AW];

  // The array is never reset so a preloaded program survives rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem.sv
// Directed self-checking bench for the unified memory.
module tb_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_err = 0;

  mem dut (
    .addr  (addr),
    .clk   (clk),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .rst   (rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b0;
    we    = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
    dut.mem[0] = 32'h0050_0093;
    dut.mem[1] = 32'h0030_8113;
    dut.mem[5] = 32'h1111_1111;
    #1;
    check("powerup_rdata", rdata, 32'h0);

    // Fetch of two preloaded instructions on consecutive cycles.
    addr = 32'd0;
    step();
    check("fetch_0", rdata, 32'h0050_0093);
    addr = 32'd1;
    step();
    check("fetch_1", rdata, 32'h0030_8113);

    // Write then read back.
    we = 1'b1; addr = 32'd10; wdata = 32'hDEAD_BEEF;
    step();
    we = 1'b0;
    step();
    check("wr_readback", rdata, 32'hDEAD_BEEF);
    check("wr_array", dut.mem[10], 32'hDEAD_BEEF);

    // Read-during-write returns the old word.
    we = 1'b1; addr = 32'd5; wdata = 32'h2222_2222;
    step();
    check("rdw_old", rdata, 32'h1111_1111);
    we = 1'b0;
    step();
    check("rdw_new", rdata, 32'h2222_2222);

    // Address wrap: 0x45 maps to index 5.
    we = 1'b1; addr = 32'h45; wdata = 32'hCAFE_F00D;
    step();
    check("wrap_rdw_old", rdata, 32'h2222_2222);
    we = 1'b0; addr = 32'd5;
    step();
    check("wrap_read", rdata, 32'hCAFE_F00D);
    check("wrap_array", dut.mem[5], 32'hCAFE_F00D);
    addr = 32'hFFFF_FFCA;
    step();
    check("wrap_hi_read", rdata, 32'hDEAD_BEEF);

    // Reset clears rdata only; a write in the reset cycle still lands.
    we = 1'b1; addr = 32'd20; wdata = 32'h1234_5678;
    step();
    we = 1'b0;
    step();
    check("pre_rst_rdata", rdata, 32'h1234_5678);
    rst = 1'b1; we = 1'b1; addr = 32'd21; wdata = 32'hA5A5_A5A5;
    step();
    check("rst_rdata", rdata, 32'h0);
    rst = 1'b0; we = 1'b0; addr = 32'd0;
    step();
    check("post_rst_preload", rdata, 32'h0050_0093);
    addr = 32'd20;
    step();
    check("post_rst_word20", rdata, 32'h1234_5678);
    addr = 32'd21;
    step();
    check("rst_cycle_write", rdata, 32'hA5A5_A5A5);

    // rdata holds between edges.
    #3;
    check("rdata_hold", rdata, 32'hA5A5_A5A5);

    // we held for three cycles: each edge writes, last one wins.
    we = 1'b1; addr = 32'd30; wdata = 32'h0000_0001;
    step();
    wdata = 32'h0000_0002;
    step();
    check("burst_rdw", rdata, 32'h0000_0001);
    wdata = 32'h0000_0003;
    step();
    check("burst_rdw2", rdata, 32'h0000_0002);
    we = 1'b0;
    step();
    check("burst_last", rdata, 32'h0000_0003);

    // X on we must not write.
    we = 1'bx; addr = 32'd10; wdata = 32'h0;
    step();
    we = 1'b0;
    check("we_x_array", dut.mem[10], 32'hDEAD_BEEF);

    // Ten idle cycles with wandering addr/wdata leave the array alone.
    for (int i = 0; i < 10; i++) begin
      addr  = i * 7;
      wdata = $urandom;
      step();
    end
    check("idle_mem0", dut.mem[0], 32'h0050_0093);
    check("idle_mem1", dut.mem[1], 32'h0030_8113);
    check("idle_mem5", dut.mem[5], 32'hCAFE_F00D);
    check("idle_mem10", dut.mem[10], 32'hDEAD_BEEF);
    check("idle_mem20", dut.mem[20], 32'h1234_5678);
    check("idle_mem21", dut.mem[21], 32'hA5A5_A5A5);
    check("idle_mem30", dut.mem[30], 32'h0000_0003);

    // Never-written word reads as X.
    addr = 32'd3;
    step();
    check("uninit_x", rdata, 32'hxxxx_xxxx);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
